// File: rtl/kd_pkg.sv
// Shared Run_mode codes, algorithm selects and phase-count helper for the KD_top
// command sequencer.
package kd_pkg;

   localparam int RM_W = 4;

   localparam logic [RM_W-1:0] RM_IDLE          = 4'd0;
   localparam logic [RM_W-1:0] RM_K_2_NTT       = 4'd1;
   localparam logic [RM_W-1:0] RM_DONE_K_2_NTT  = 4'd2;
   localparam logic [RM_W-1:0] RM_K_4_NTT       = 4'd3;
   localparam logic [RM_W-1:0] RM_DONE_K_4_NTT  = 4'd4;
   localparam logic [RM_W-1:0] RM_D_2_NTT       = 4'd5;
   localparam logic [RM_W-1:0] RM_DONE_D_2_NTT  = 4'd6;
   localparam logic [RM_W-1:0] RM_K_2_INTT      = 4'd7;
   localparam logic [RM_W-1:0] RM_DONE_K_2_INTT = 4'd8;
   localparam logic [RM_W-1:0] RM_K_4_INTT      = 4'd9;
   localparam logic [RM_W-1:0] RM_DONE_K_4_INTT = 4'd10;
   localparam logic [RM_W-1:0] RM_D_2_INTT      = 4'd11;
   localparam logic [RM_W-1:0] RM_DONE_D_2_INTT = 4'd12;

   localparam logic KD_KYBER     = 1'b0;
   localparam logic KD_DILITHIUM = 1'b1;

   function automatic logic [1:0] phase_count(input logic kd);
      return (kd == KD_DILITHIUM) ? 2'd1 : 2'd2;
   endfunction

endpackage

// File: rtl/kd_phase_rom.sv
// Combinational lookup of the RUN-phase code for a given algorithm, direction
// and phase index; out-of-range indices return IDLE.
module kd_phase_rom
   import kd_pkg::*;
(
   input  logic            i_kd_mode,
   input  logic            i_inverse,
   input  logic            i_index,
   output logic [RM_W-1:0] o_code
);

   always_comb begin
      o_code = RM_IDLE;
      case ({i_kd_mode, i_inverse, i_index})
         3'b000:  o_code = RM_K_2_NTT;
         3'b001:  o_code = RM_K_4_NTT;
         3'b010:  o_code = RM_K_4_INTT;
         3'b011:  o_code = RM_K_2_INTT;
         3'b100:  o_code = RM_D_2_NTT;
         3'b110:  o_code = RM_D_2_INTT;
         default: o_code = RM_IDLE;
      endcase
   end

endmodule

// File: rtl/kd_run_seq.sv
// Handshake-driven, timeout-guarded sequencer that steps KD_top through the
// RUN/Done phase codes of one NTT/INTT request.
module kd_run_seq
   import kd_pkg::*;
#(
   parameter int DONE_HOLD = 16,
   parameter int TIMEOUT   = 2048
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_kd_mode,
   input  logic            cmd_inverse,
   input  logic [1:0]      done_flag,
   output logic [RM_W-1:0] Run_mode,
   output logic            KD_mode,
   output logic            busy,
   output logic            op_done,
   output logic            op_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
   localparam logic [1:0] ST_FIN  = 2'd3;

   localparam logic [7:0]  HOLD_LAST = 8'(DONE_HOLD - 1);
   localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

   logic [1:0]      r_state;
   logic            r_inv;
   logic            r_idx;
   logic [7:0]      r_hcnt;
   logic [15:0]     r_tcnt;
   logic [1:0]      r_flag_d;
   logic [RM_W-1:0] r_run_mode;
   logic            r_kd_mode;
   logic            r_busy;
   logic            r_op_done;
   logic            r_op_err;
   logic            r_cmd_ready;

   logic            w_rom_kd;
   logic            w_rom_inv;
   logic            w_rom_idx;
   logic [RM_W-1:0] w_rom_code;
   logic            w_rise;
   logic            w_last;

   // In IDLE the ROM looks up phase 0 of the incoming command; otherwise the next phase.
   assign w_rom_kd  = (r_state == ST_IDLE) ? cmd_kd_mode : r_kd_mode;
   assign w_rom_inv = (r_state == ST_IDLE) ? cmd_inverse : r_inv;
   assign w_rom_idx = (r_state == ST_IDLE) ? 1'b0 : (r_idx + 1'b1);

   kd_phase_rom u_rom (
      .i_kd_mode (w_rom_kd),
      .i_inverse (w_rom_inv),
      .i_index   (w_rom_idx),
      .o_code    (w_rom_code)
   );

   // Only a 00 -> nonzero edge counts, so a flag left high from the last phase is ignored.
   assign w_rise = (r_flag_d == 2'b00) && (done_flag != 2'b00);
   assign w_last = (({1'b0, r_idx} + 2'd1) >= phase_count(r_kd_mode));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_inv       <= 1'b0;
         r_idx       <= 1'b0;
         r_hcnt      <= 8'd0;
         r_tcnt      <= 16'd0;
         r_flag_d    <= 2'b00;
         r_run_mode  <= RM_IDLE;
         r_kd_mode   <= KD_KYBER;
         r_busy      <= 1'b0;
         r_op_done   <= 1'b0;
         r_op_err    <= 1'b0;
         r_cmd_ready <= 1'b1;
      end else begin
         r_flag_d  <= done_flag;
         r_op_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid && r_cmd_ready) begin
                  r_kd_mode   <= cmd_kd_mode;
                  r_inv       <= cmd_inverse;
                  r_idx       <= 1'b0;
                  r_op_err    <= 1'b0;
                  r_run_mode  <= w_rom_code;
                  r_tcnt      <= 16'd0;
                  r_hcnt      <= 8'd0;
                  r_busy      <= 1'b1;
                  r_cmd_ready <= 1'b0;
                  r_state     <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_rise) begin
                  r_run_mode <= r_run_mode + 4'd1;
                  r_hcnt     <= 8'd0;
                  r_state    <= ST_HOLD;
               end else if (r_tcnt == TMO_LAST) begin
                  r_run_mode <= RM_IDLE;
                  r_op_err   <= 1'b1;
                  r_op_done  <= 1'b1;
                  r_tcnt     <= 16'd0;
                  r_state    <= ST_FIN;
               end else begin
                  r_tcnt <= r_tcnt + 16'd1;
               end
            end
            ST_HOLD: begin
               if (r_hcnt == HOLD_LAST) begin
                  r_hcnt <= 8'd0;
                  if (!w_last) begin
                     r_idx      <= r_idx + 1'b1;
                     r_run_mode <= w_rom_code;
                     r_tcnt     <= 16'd0;
                     r_state    <= ST_RUN;
                  end else begin
                     r_run_mode <= RM_IDLE;
                     r_op_done  <= 1'b1;
                     r_state    <= ST_FIN;
                  end
               end else begin
                  r_hcnt <= r_hcnt + 8'd1;
               end
            end
            ST_FIN: begin
               r_busy      <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
            default: begin
               r_run_mode  <= RM_IDLE;
               r_busy      <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign Run_mode  = r_run_mode;
   assign KD_mode   = r_kd_mode;
   assign busy      = r_busy;
   assign op_done   = r_op_done;
   assign op_err    = r_op_err;

endmodule

// File: tb/tb_kd_run_seq.sv
// Randomized bench for kd_run_seq; expected Run_mode traces come from the phase
// lists and the chosen done_flag timing.
module tb_kd_run_seq;

   localparam int DH = 16;
   localparam int TO = 2048;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_kd_mode;
   logic       cmd_inverse;
   logic [1:0] done_flag;
   logic [3:0] Run_mode;
   logic       KD_mode;
   logic       busy;
   logic       op_done;
   logic       op_err;

   int n_cmp = 0;
   int n_bad = 0;

   kd_run_seq #(.DONE_HOLD(DH), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_kd_mode (cmd_kd_mode),
      .cmd_inverse (cmd_inverse),
      .done_flag   (done_flag),
      .Run_mode    (Run_mode),
      .KD_mode     (KD_mode),
      .busy        (busy),
      .op_done     (op_done),
      .op_err      (op_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One full request. fixed_dly >= 0 forces the flag-rise cycle of every phase.
   task automatic run_op(input logic kd, input logic inv, input int fixed_dly,
                         input bit hold_v, input bit stale, input bit tmo, input bit abort_h);
      logic [3:0] codes [2];
      int np, dly, sdrop, limit;
      if (kd) begin
         np = 1;
         codes[0] = inv ? 4'd11 : 4'd5;
         codes[1] = 4'd0;
      end else begin
         np = 2;
         codes[0] = inv ? 4'd9 : 4'd1;
         codes[1] = inv ? 4'd7 : 4'd3;
      end
      cmd_valid = 1'b1; cmd_kd_mode = kd; cmd_inverse = inv;
      step();
      chk("accept_busy", busy, 1);
      chk("accept_ready", cmd_ready, 0);
      chk("accept_err", op_err, 0);
      if (!hold_v) cmd_valid = 1'b0;
      for (int p = 0; p < np; p++) begin
         dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 40));
         if (stale && p > 0 && dly < 2) dly = 2;
         sdrop = (dly > 0) ? int'($urandom_range(0, dly - 1)) : 0;
         limit = tmo ? TO : dly + 1;
         for (int c = 0; c < limit; c++) begin
            chk("run_code", Run_mode, codes[p]);
            chk("run_busy", busy, 1);
            chk("run_ready", cmd_ready, 0);
            chk("run_done", op_done, 0);
            chk("run_err", op_err, 0);
            chk("run_kd", KD_mode, kd);
            if (!tmo) begin
               if (stale && p > 0 && c == sdrop) done_flag = 2'b00;
               if (c == dly) done_flag = 2'($urandom_range(1, 3));
            end
            cmd_kd_mode = 1'($urandom); cmd_inverse = 1'($urandom);
            step();
         end
         if (tmo) begin
            chk("tmo_code", Run_mode, 0);
            chk("tmo_done", op_done, 1);
            chk("tmo_err", op_err, 1);
            step();
            chk("tmo_done_clr", op_done, 0);
            chk("tmo_err_sticky", op_err, 1);
            chk("tmo_ready", cmd_ready, 1);
            chk("tmo_busy", busy, 0);
            return;
         end
         for (int h = 0; h < DH; h++) begin
            chk("hold_code", Run_mode, codes[p] + 4'd1);
            chk("hold_busy", busy, 1);
            chk("hold_done", op_done, 0);
            if (!stale && h == 0) done_flag = 2'b00;
            if (abort_h && p == np - 1 && h == DH / 2) begin
               rst = 1'b0;
               #1;
               chk("abort_code", Run_mode, 0);
               chk("abort_busy", busy, 0);
               chk("abort_ready", cmd_ready, 1);
               chk("abort_kd", KD_mode, 0);
               chk("abort_done", op_done, 0);
               chk("abort_err", op_err, 0);
               done_flag = 2'b00; cmd_valid = 1'b0;
               step();
               chk("abort_hold_code", Run_mode, 0);
               rst = 1'b1;
               step();
               return;
            end
            step();
         end
      end
      chk("fin_code", Run_mode, 0);
      chk("fin_done", op_done, 1);
      chk("fin_busy", busy, 1);
      chk("fin_ready", cmd_ready, 0);
      chk("fin_err", op_err, 0);
      done_flag = 2'b00;
      step();
      chk("idle_done", op_done, 0);
      chk("idle_ready", cmd_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_code", Run_mode, 0);
   endtask

   initial begin
      rst = 1'b0; cmd_valid = 1'b0; cmd_kd_mode = 1'b0; cmd_inverse = 1'b0; done_flag = 2'b00;
      #12;
      chk("rst_code", Run_mode, 0);
      chk("rst_kd", KD_mode, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", op_done, 0);
      chk("rst_err", op_err, 0);
      chk("rst_ready", cmd_ready, 1);
      rst = 1'b1;
      step();
      step();

      // Directed: Kyber NTT with flag at cycle 30, then Dilithium INTT.
      run_op(1'b0, 1'b0, 30, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      run_op(1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      // Stale flag carried from HOLD into the next RUN.
      run_op(1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      run_op(1'b0, 1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b0);
      step();

      // Randomized requests.
      for (int i = 0; i < 8; i++) begin
         run_op(1'($urandom), 1'($urandom), -1, 1'b0, 1'($urandom), 1'b0, 1'b0);
         for (int k = 0; k < int'($urandom_range(0, 3)); k++) step();
      end

      // Timeout, then op_err must persist while idle and clear on accept.
      run_op(1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         chk("err_idle_sticky", op_err, 1);
         step();
      end
      run_op(1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();

      // Back-pressure: valid held across a Kyber INTT, second request starts right after.
      run_op(1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 1'b0);
      run_op(1'b0, 1'b1, -1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();

      // Reset while Run_mode=4, then a clean restart.
      run_op(1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b1);
      run_op(1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
